// File: rtl/morse_pkg.sv
// Shared constants, FSM state type and Morse lookup helpers for the sequencer.
// Character classification and the symbol table live here so the encoder stays a thin shell.
package morse_pkg;

    localparam int CODE_WIDTH = 20;

    localparam logic [7:0] ASCII_SPACE    = 8'h20;
    localparam logic [7:0] ASCII_A        = 8'h41;
    localparam logic [7:0] ASCII_Z        = 8'h5A;
    localparam logic [7:0] ASCII_0        = 8'h30;
    localparam logic [7:0] ASCII_9        = 8'h39;
    localparam logic [7:0] CASE_FOLD_MASK = 8'hDF;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_FETCH,
        ST_LOOK,
        ST_ISSUE,
        ST_WAIT_ACK,
        ST_WAIT_DONE
    } state_e;

    function automatic logic [7:0] fold_case(input logic [7:0] c);
        logic [7:0] f;
        f = c & CASE_FOLD_MASK;
        return (f >= ASCII_A && f <= ASCII_Z) ? f : c;
    endfunction

    // Returns {symbol count, symbols}; symbols are right-aligned, first symbol
    // in the highest used bit, 1 = dash. A count of zero marks an unsupported code.
    function automatic logic [7:0] morse_symbols(input logic [7:0] c);
        logic [7:0] sym;
        case (c)
            "A": sym = {3'd2, 5'b00001};
            "B": sym = {3'd4, 5'b01000};
            "C": sym = {3'd4, 5'b01010};
            "D": sym = {3'd3, 5'b00100};
            "E": sym = {3'd1, 5'b00000};
            "F": sym = {3'd4, 5'b00010};
            "G": sym = {3'd3, 5'b00110};
            "H": sym = {3'd4, 5'b00000};
            "I": sym = {3'd2, 5'b00000};
            "J": sym = {3'd4, 5'b00111};
            "K": sym = {3'd3, 5'b00101};
            "L": sym = {3'd4, 5'b00100};
            "M": sym = {3'd2, 5'b00011};
            "N": sym = {3'd2, 5'b00010};
            "O": sym = {3'd3, 5'b00111};
            "P": sym = {3'd4, 5'b00110};
            "Q": sym = {3'd4, 5'b01101};
            "R": sym = {3'd3, 5'b00010};
            "S": sym = {3'd3, 5'b00000};
            "T": sym = {3'd1, 5'b00001};
            "U": sym = {3'd3, 5'b00001};
            "V": sym = {3'd4, 5'b00001};
            "W": sym = {3'd3, 5'b00011};
            "X": sym = {3'd4, 5'b01001};
            "Y": sym = {3'd4, 5'b01011};
            "Z": sym = {3'd4, 5'b01100};
            "0": sym = {3'd5, 5'b11111};
            "1": sym = {3'd5, 5'b01111};
            "2": sym = {3'd5, 5'b00111};
            "3": sym = {3'd5, 5'b00011};
            "4": sym = {3'd5, 5'b00001};
            "5": sym = {3'd5, 5'b00000};
            "6": sym = {3'd5, 5'b10000};
            "7": sym = {3'd5, 5'b11000};
            "8": sym = {3'd5, 5'b11100};
            "9": sym = {3'd5, 5'b11110};
            default: sym = 8'h00;
        endcase
        return sym;
    endfunction

endpackage

// File: rtl/morse_encoder.sv
// Combinational ASCII to left-aligned Morse pattern encoder (dot = 10, dash = 1110).
// Lower case folds to upper case; space is flagged separately and never encoded.
module morse_encoder
    import morse_pkg::*;
(
    input  logic [7:0]            char_i,
    output logic                  valid_o,
    output logic                  is_space_o,
    output logic [CODE_WIDTH-1:0] code_o
);

    logic [7:0]            folded;
    logic [2:0]            sym_len;
    logic [4:0]            sym_bits;
    logic [CODE_WIDTH-1:0] acc;
    logic [4:0]            nbits;

    // Symbols are shifted in from the right, then the whole pattern is pushed up to the MSB.
    always_comb begin
        folded              = fold_case(char_i);
        {sym_len, sym_bits} = morse_symbols(folded);
        acc                 = '0;
        nbits               = '0;
        for (int i = 4; i >= 0; i--) begin
            if (i < int'(sym_len)) begin
                if (sym_bits[i]) begin
                    acc   = {acc[CODE_WIDTH-5:0], 4'b1110};
                    nbits = nbits + 5'd4;
                end else begin
                    acc   = {acc[CODE_WIDTH-3:0], 2'b10};
                    nbits = nbits + 5'd2;
                end
            end
        end
        code_o     = acc << (5'(CODE_WIDTH) - nbits);
        valid_o    = (sym_len != 3'd0);
        is_space_o = (char_i == ASCII_SPACE);
    end

endmodule

// File: rtl/morse_sequencer.sv
// Character queue plus issue FSM feeding the LED blinker over its read/ready handshake.
// Each pattern carries the gap stretch (s3 letter / s7 word) decided by peeking at the next char.
module morse_sequencer #(
    parameter int FIFO_DEPTH = 8,
    parameter int CODE_WIDTH = 20
) (
    input  logic                  i_clk,
    input  logic                  i_rst,
    input  logic [7:0]            i_char,
    input  logic                  i_char_valid,
    output logic                  o_char_ready,
    output logic [CODE_WIDTH-1:0] o_morse_code,
    output logic                  o_read,
    output logic                  o_s3,
    output logic                  o_s7,
    input  logic                  i_blink_ready,
    output logic                  o_busy,
    output logic                  o_bad_char
);

    import morse_pkg::*;

    localparam int ADDR_W = $clog2(FIFO_DEPTH);

    logic [7:0]            mem_q [FIFO_DEPTH];
    logic [ADDR_W:0]       wr_ptr_q, wr_ptr_d;
    logic [ADDR_W:0]       rd_ptr_q, rd_ptr_d;
    logic                  empty, full, push, pop;
    logic [7:0]            head;
    logic                  head_valid, head_space;
    logic [CODE_WIDTH-1:0] head_code;

    state_e                state_q;
    logic [CODE_WIDTH-1:0] code_q;
    logic                  read_q, s3_q, s7_q, bad_q;

    assign head  = mem_q[rd_ptr_q[ADDR_W-1:0]];
    assign empty = (wr_ptr_q == rd_ptr_q);
    assign full  = (wr_ptr_q[ADDR_W] != rd_ptr_q[ADDR_W]) &&
                   (wr_ptr_q[ADDR_W-1:0] == rd_ptr_q[ADDR_W-1:0]);

    // Pops depend only on registered state, so ready can advertise the slot a pop frees.
    assign pop = !empty && ((state_q == ST_FETCH) || (state_q == ST_LOOK && head_space));
    assign o_char_ready = !full || pop;
    assign push         = i_char_valid && o_char_ready;

    assign wr_ptr_d = wr_ptr_q + {{ADDR_W{1'b0}}, push};
    assign rd_ptr_d = rd_ptr_q + {{ADDR_W{1'b0}}, pop};

    morse_encoder u_encoder (
        .char_i     (head),
        .valid_o    (head_valid),
        .is_space_o (head_space),
        .code_o     (head_code)
    );

    always_ff @(posedge i_clk) begin
        if (push) begin
            mem_q[wr_ptr_q[ADDR_W-1:0]] <= i_char;
        end
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
        end
    end

    // An unsupported char at the head during LOOK requests no stretch; it is dropped later in FETCH.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state_q <= ST_IDLE;
            code_q  <= '0;
            read_q  <= 1'b0;
            s3_q    <= 1'b0;
            s7_q    <= 1'b0;
            bad_q   <= 1'b0;
        end else begin
            bad_q <= 1'b0;
            unique case (state_q)
                ST_IDLE: begin
                    if (!empty) begin
                        state_q <= ST_FETCH;
                    end
                end
                ST_FETCH: begin
                    if (empty) begin
                        state_q <= ST_IDLE;
                    end else if (head_valid) begin
                        code_q  <= head_code;
                        state_q <= ST_LOOK;
                    end else if (!head_space) begin
                        bad_q <= 1'b1;
                    end
                end
                ST_LOOK: begin
                    s3_q    <= !empty && head_valid;
                    s7_q    <= !empty && head_space;
                    state_q <= ST_ISSUE;
                end
                ST_ISSUE: begin
                    if (i_blink_ready) begin
                        read_q  <= 1'b1;
                        state_q <= ST_WAIT_ACK;
                    end
                end
                ST_WAIT_ACK: begin
                    if (!i_blink_ready) begin
                        read_q  <= 1'b0;
                        state_q <= ST_WAIT_DONE;
                    end
                end
                ST_WAIT_DONE: begin
                    if (i_blink_ready) begin
                        s3_q    <= 1'b0;
                        s7_q    <= 1'b0;
                        state_q <= empty ? ST_IDLE : ST_FETCH;
                    end
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    assign o_morse_code = code_q;
    assign o_read       = read_q;
    assign o_s3         = s3_q;
    assign o_s7         = s7_q;
    assign o_bad_char   = bad_q;
    assign o_busy       = (state_q != ST_IDLE) || !empty;

endmodule

// File: tb/tb_morse_sequencer.sv
// Bench for morse_sequencer: a behavioural blinker responder plus a string-table Morse model.
module tb_morse_sequencer;

    localparam int FIFO_DEPTH = 8;
    localparam int CW         = 20;

    logic          clk = 1'b0;
    logic          rst;
    logic [7:0]    charIn;
    logic          charValid;
    logic          charReady;
    logic [CW-1:0] morseCode;
    logic          readO, s3, s7;
    logic          blinkReady;
    logic          busy, badChar;

    int checks   = 0;
    int failures = 0;

    logic          respEnable  = 1'b0;
    logic          manualReady = 1'b1;
    logic [CW-1:0] capCode[$];
    logic          capS3[$];
    logic          capS7[$];
    int            badSeen     = 0;
    int            readRiseBad = 0;

    logic [CW-1:0] expCode[$];
    logic          expS3[$];
    logic          expS7[$];
    int            expBad;

    string letterCodes[26] = '{".-", "-...", "-.-.", "-..", ".", "..-.", "--.", "....", "..",
                               ".---", "-.-", ".-..", "--", "-.", "---", ".--.", "--.-", ".-.",
                               "...", "-", "..-", "...-", ".--", "-..-", "-.--", "--.."};
    string digitCodes[10]  = '{"-----", ".----", "..---", "...--", "....-",
                               ".....", "-....", "--...", "---..", "----."};

    morse_sequencer #(
        .FIFO_DEPTH (FIFO_DEPTH),
        .CODE_WIDTH (CW)
    ) dut (
        .i_clk         (clk),
        .i_rst         (rst),
        .i_char        (charIn),
        .i_char_valid  (charValid),
        .o_char_ready  (charReady),
        .o_morse_code  (morseCode),
        .o_read        (readO),
        .o_s3          (s3),
        .o_s7          (s7),
        .i_blink_ready (blinkReady),
        .o_busy        (busy),
        .o_bad_char    (badChar)
    );

    initial forever #5 clk = ~clk;

    // Blinker stand-in: loads on read while ready, stays busy a few random cycles.
    initial begin
        int   busyLeft;
        logic prevRead;
        logic sRead;
        busyLeft   = 0;
        prevRead   = 1'b0;
        blinkReady = 1'b1;
        forever begin
            @(negedge clk);
            sRead = readO;
            if (sRead && !prevRead && !blinkReady) readRiseBad++;
            prevRead = sRead;
            if (badChar) badSeen++;
            #2;
            if (rst) begin
                blinkReady = 1'b1;
                busyLeft   = 0;
            end else if (!respEnable) begin
                blinkReady = manualReady;
            end else if (blinkReady && sRead) begin
                capCode.push_back(morseCode);
                capS3.push_back(s3);
                capS7.push_back(s7);
                blinkReady = 1'b0;
                busyLeft   = $urandom_range(0, 3);
            end else if (!blinkReady) begin
                if (busyLeft > 0) busyLeft--;
                else blinkReady = 1'b1;
            end
        end
    end

    function automatic logic [7:0] foldChar(input logic [7:0] c);
        return (c >= 8'h61 && c <= 8'h7A) ? c - 8'd32 : c;
    endfunction

    function automatic bit isSupported(input logic [7:0] c);
        logic [7:0] f;
        f = foldChar(c);
        return (f >= 8'h41 && f <= 8'h5A) || (f >= 8'h30 && f <= 8'h39);
    endfunction

    function automatic logic [CW-1:0] refCode(input logic [7:0] c);
        logic [7:0]      f;
        string           s;
        longint unsigned bits;
        int              n;
        f    = foldChar(c);
        bits = 0;
        n    = 0;
        if (f >= 8'h41 && f <= 8'h5A) s = letterCodes[int'(f) - 65];
        else s = digitCodes[int'(f) - 48];
        for (int k = 0; k < s.len(); k++) begin
            if (s[k] == ".") begin
                bits = bits * 4 + 2;
                n += 2;
            end else begin
                bits = bits * 16 + 14;
                n += 4;
            end
        end
        return CW'(bits << (CW - n));
    endfunction

    // Expected issues: each supported char, gap chosen by the char that follows it.
    task automatic modelMessage(input logic [7:0] msg[$]);
        int i;
        bit nextSpace, nextAlnum;
        expCode.delete();
        expS3.delete();
        expS7.delete();
        expBad = 0;
        i = 0;
        while (i < msg.size()) begin
            if (msg[i] == 8'h20) begin
                i++;
            end else if (!isSupported(msg[i])) begin
                expBad++;
                i++;
            end else begin
                nextSpace = (i + 1 < msg.size()) && (msg[i+1] == 8'h20);
                nextAlnum = (i + 1 < msg.size()) && isSupported(msg[i+1]);
                expCode.push_back(refCode(msg[i]));
                expS3.push_back(nextAlnum);
                expS7.push_back(nextSpace);
                i += nextSpace ? 2 : 1;
            end
        end
    endtask

    task automatic applyStimulus(input logic [7:0] msg[$]);
        int waitCycles;
        for (int i = 0; i < msg.size(); i++) begin
            waitCycles = 0;
            charIn     = msg[i];
            charValid  = 1'b1;
            while (!charReady && waitCycles < 500) begin
                @(negedge clk);
                waitCycles++;
            end
            if (!charReady) begin
                checks++;
                failures++;
                $display("[TB] FAIL push_timeout: char %h ready=%0b required 1", msg[i], charReady);
            end
            @(negedge clk);
        end
        charValid = 1'b0;
    endtask

    task automatic waitIdle(output bit done);
        int waitCycles;
        waitCycles = 0;
        while ((busy || !blinkReady) && waitCycles < 3000) begin
            @(negedge clk);
            waitCycles++;
        end
        done = !busy && blinkReady;
    endtask

    task automatic test_reset();
        checks++; if (charReady !== 1'b1) begin failures++; $display("[TB] FAIL reset_ready: got %b required 1", charReady); end
        checks++; if (readO !== 1'b0) begin failures++; $display("[TB] FAIL reset_read: got %b required 0", readO); end
        checks++; if (s3 !== 1'b0 || s7 !== 1'b0) begin failures++; $display("[TB] FAIL reset_gap: got s3=%b s7=%b required 0 0", s3, s7); end
        checks++; if (morseCode !== '0) begin failures++; $display("[TB] FAIL reset_code: got %h required 00000", morseCode); end
        checks++; if (busy !== 1'b0) begin failures++; $display("[TB] FAIL reset_busy: got %b required 0", busy); end
        checks++; if (badChar !== 1'b0) begin failures++; $display("[TB] FAIL reset_bad: got %b required 0", badChar); end
    endtask

    task automatic test_spec_examples();
        string         texts[4]     = '{"E", "AT", "E  T", "a#0"};
        logic [CW-1:0] firstCode[4] = '{20'h80000, 20'hB8000, 20'h80000, 20'hB8000};
        int            issues[4]    = '{1, 2, 2, 2};
        int            bads[4]      = '{0, 0, 0, 1};
        logic [7:0]    msg[$];
        int            capBase, badBase;
        bit            done;
        for (int t = 0; t < 4; t++) begin
            msg.delete();
            for (int k = 0; k < texts[t].len(); k++) msg.push_back(texts[t][k]);
            modelMessage(msg);
            capBase = capCode.size();
            badBase = badSeen;
            applyStimulus(msg);
            waitIdle(done);
            checks++;
            if (!done) begin failures++; $display("[TB] FAIL %s idle_timeout: busy=%0b ready=%0b required 0 1", texts[t], busy, blinkReady); end
            checks++;
            if (capCode.size() - capBase != issues[t]) begin
                failures++;
                $display("[TB] FAIL %s issue_count: got %0d required %0d", texts[t], capCode.size() - capBase, issues[t]);
            end
            checks++;
            if (capCode.size() > capBase && capCode[capBase] !== firstCode[t]) begin
                failures++;
                $display("[TB] FAIL %s first_code: got %h required %h", texts[t], capCode[capBase], firstCode[t]);
            end
            for (int k = 0; k < expCode.size(); k++) begin
                if (capBase + k >= capCode.size()) break;
                checks++;
                if (capCode[capBase+k] !== expCode[k]) begin failures++; $display("[TB] FAIL %s code[%0d]: got %h required %h", texts[t], k, capCode[capBase+k], expCode[k]); end
                checks++;
                if (capS3[capBase+k] !== expS3[k] || capS7[capBase+k] !== expS7[k]) begin
                    failures++;
                    $display("[TB] FAIL %s gap[%0d]: got s3=%b s7=%b required s3=%b s7=%b", texts[t], k, capS3[capBase+k], capS7[capBase+k], expS3[k], expS7[k]);
                end
            end
            checks++;
            if (badSeen - badBase != bads[t]) begin failures++; $display("[TB] FAIL %s bad_pulses: got %0d required %0d", texts[t], badSeen - badBase, bads[t]); end
        end
    endtask

    task automatic test_fifo_full();
        logic [7:0] msg[$];
        respEnable  = 1'b0;
        manualReady = 1'b0;
        @(negedge clk);
        msg.delete();
        msg.push_back("E");
        applyStimulus(msg);
        repeat (6) @(negedge clk);
        for (int k = 0; k < 9; k++) begin
            charIn    = "T";
            charValid = 1'b1;
            checks++;
            if (charReady !== (k < 8)) begin
                failures++;
                $display("[TB] FAIL full_ready[%0d]: got %b required %b", k, charReady, (k < 8));
            end
            @(negedge clk);
        end
        charValid = 1'b0;
        checks++; if (charReady !== 1'b0) begin failures++; $display("[TB] FAIL full_hold: ready got %b required 0", charReady); end
        checks++; if (busy !== 1'b1) begin failures++; $display("[TB] FAIL full_busy: got %b required 1", busy); end
        checks++; if (readO !== 1'b0) begin failures++; $display("[TB] FAIL read_while_busy: got %b required 0", readO); end
    endtask

    task automatic test_reset_mid_transfer();
        manualReady = 1'b1;
        @(negedge clk);
        checks++; if (readO !== 1'b1) begin failures++; $display("[TB] FAIL ack_read: got %b required 1", readO); end
        rst = 1'b1;
        @(posedge clk);
        #1;
        checks++; if (readO !== 1'b0) begin failures++; $display("[TB] FAIL rst_read: got %b required 0", readO); end
        checks++; if (busy !== 1'b0) begin failures++; $display("[TB] FAIL rst_busy: got %b required 0", busy); end
        checks++; if (charReady !== 1'b1) begin failures++; $display("[TB] FAIL rst_ready: got %b required 1", charReady); end
        @(negedge clk);
        rst        = 1'b0;
        respEnable = 1'b1;
        repeat (2) @(negedge clk);
    endtask

    task automatic test_random();
        logic [7:0] badPool[5] = '{8'h23, 8'h21, 8'h2E, 8'h7F, 8'hC5};
        logic [7:0] msg[$];
        int         len, r, capBase, badBase;
        bit         done;
        for (int m = 0; m < 12; m++) begin
            msg.delete();
            len = $urandom_range(1, 14);
            for (int k = 0; k < len; k++) begin
                r = $urandom_range(0, 99);
                if (r < 40)      msg.push_back(8'(8'h41 + $urandom_range(0, 25)));
                else if (r < 55) msg.push_back(8'(8'h61 + $urandom_range(0, 25)));
                else if (r < 70) msg.push_back(8'(8'h30 + $urandom_range(0, 9)));
                else if (r < 85) msg.push_back(8'h20);
                else             msg.push_back(badPool[$urandom_range(0, 4)]);
            end
            modelMessage(msg);
            capBase = capCode.size();
            badBase = badSeen;
            applyStimulus(msg);
            waitIdle(done);
            checks++;
            if (!done) begin failures++; $display("[TB] FAIL rand%0d idle_timeout: busy=%0b ready=%0b required 0 1", m, busy, blinkReady); end
            checks++;
            if (capCode.size() - capBase != expCode.size()) begin
                failures++;
                $display("[TB] FAIL rand%0d issue_count: got %0d required %0d", m, capCode.size() - capBase, expCode.size());
            end
            for (int k = 0; k < expCode.size(); k++) begin
                if (capBase + k >= capCode.size()) break;
                checks++;
                if (capCode[capBase+k] !== expCode[k]) begin failures++; $display("[TB] FAIL rand%0d code[%0d]: got %h required %h", m, k, capCode[capBase+k], expCode[k]); end
                checks++;
                if (capS3[capBase+k] !== expS3[k] || capS7[capBase+k] !== expS7[k]) begin
                    failures++;
                    $display("[TB] FAIL rand%0d gap[%0d]: got s3=%b s7=%b required s3=%b s7=%b", m, k, capS3[capBase+k], capS7[capBase+k], expS3[k], expS7[k]);
                end
            end
            checks++;
            if (badSeen - badBase != expBad) begin failures++; $display("[TB] FAIL rand%0d bad_pulses: got %0d required %0d", m, badSeen - badBase, expBad); end
        end
    endtask

    initial begin
        rst       = 1'b1;
        charValid = 1'b0;
        charIn    = 8'h00;
        repeat (3) @(negedge clk);
        test_reset();
        rst = 1'b0;
        @(negedge clk);
        respEnable = 1'b1;
        repeat (2) @(negedge clk);
        $display("[TB] spec example messages");
        test_spec_examples();
        $display("[TB] queue full with blinker held busy");
        test_fifo_full();
        $display("[TB] reset during handshake");
        test_reset_mid_transfer();
        $display("[TB] random messages");
        test_random();
        checks++;
        if (readRiseBad != 0) begin failures++; $display("[TB] FAIL read_rise_guard: got %0d rises while not ready required 0", readRiseBad); end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
